// File: rtl/branch_pkg.sv
// Shared types and next-PC helper for the branch resolution unit.
// The prediction entry width is fixed here; the top's DATA_WIDTH defaults to it.
package branch_pkg;

  localparam int BR_DATA_W = 32;
  localparam logic [BR_DATA_W-1:0] PC_INC = BR_DATA_W'(4);

  typedef struct packed {
    logic [BR_DATA_W-1:0] pc;
    logic                 hit;
    logic                 pred;
    logic [BR_DATA_W-1:0] target;
  } pred_entry_t;

  // Sequential fall-through wraps modulo 2^BR_DATA_W.
  function automatic logic [BR_DATA_W-1:0] next_pc(
    input logic                 take,
    input logic [BR_DATA_W-1:0] pc,
    input logic [BR_DATA_W-1:0] target
  );
    return take ? target : pc + PC_INC;
  endfunction

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of fetch-time predictions with a single-cycle flush.
// Head is a combinational read of the oldest entry.
module pred_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  pred_entry_t i_wr_entry,
  output pred_entry_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pred_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push_ok && !w_pop_ok)
        r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push_ok && w_pop_ok)
        r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_wr_entry;
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves in-flight branch predictions in EX, drives predictor/BTB updates,
// raises a one-cycle fetch redirect on mispredict and keeps statistics.
module branch_resolution_unit
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH  = BR_DATA_W,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fetch_valid,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  input  logic                  fetch_hit,
  input  logic                  fetch_pred,
  input  logic [DATA_WIDTH-1:0] fetch_target,
  output logic                  queue_full,
  input  logic                  resolve_valid,
  input  logic                  resolve_is_cond,
  input  logic                  resolve_is_jump,
  input  logic                  resolve_taken,
  input  logic [DATA_WIDTH-1:0] resolve_target,
  output logic                  update_predictor,
  output logic                  update_btb,
  output logic                  actually_taken,
  output logic [DATA_WIDTH-1:0] resolved_pc,
  output logic [DATA_WIDTH-1:0] resolved_pc_target,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count,
  output logic                  underflow_err
);

  pred_entry_t w_wr_entry;
  pred_entry_t w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_act_taken;
  logic        w_flush;
  logic        w_is_branch;
  logic [DATA_WIDTH-1:0] w_pred_next;
  logic [DATA_WIDTH-1:0] w_act_next;

  logic                  r_update_predictor;
  logic                  r_update_btb;
  logic                  r_actually_taken;
  logic [DATA_WIDTH-1:0] r_resolved_pc;
  logic [DATA_WIDTH-1:0] r_resolved_pc_target;
  logic                  r_redirect_valid;
  logic [DATA_WIDTH-1:0] r_redirect_pc;
  logic [CNT_WIDTH-1:0]  r_branch_count;
  logic [CNT_WIDTH-1:0]  r_mispredict_count;
  logic                  r_underflow_err;

  assign w_wr_entry = '{pc: fetch_pc, hit: fetch_hit, pred: fetch_pred, target: fetch_target};

  pred_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_pred_queue (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_wr_entry (w_wr_entry),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_pop       = resolve_valid && !w_empty;
  assign w_is_branch = resolve_is_cond || resolve_is_jump;
  assign w_act_taken = resolve_is_jump || (resolve_is_cond && resolve_taken);
  assign w_pred_next = next_pc(w_head.hit && w_head.pred, w_head.pc, w_head.target);
  assign w_act_next  = next_pc(w_act_taken, w_head.pc, resolve_target);
  // Any disagreement flushes, including a taken BTB alias on a non-branch.
  assign w_flush     = w_pop && (w_pred_next != w_act_next);
  // Fetches in the detection and redirect cycles are wrong-path and dropped.
  assign w_push      = fetch_valid && (!w_full || w_pop) && !w_flush && !r_redirect_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_update_predictor   <= 1'b0;
      r_update_btb         <= 1'b0;
      r_actually_taken     <= 1'b0;
      r_resolved_pc        <= '0;
      r_resolved_pc_target <= '0;
      r_redirect_valid     <= 1'b0;
      r_redirect_pc        <= '0;
      r_branch_count       <= '0;
      r_mispredict_count   <= '0;
      r_underflow_err      <= 1'b0;
    end else begin
      r_update_predictor <= w_pop && resolve_is_cond;
      r_update_btb       <= w_pop && w_act_taken;
      r_actually_taken   <= w_pop && w_act_taken;
      r_redirect_valid   <= w_flush;
      if (w_pop) begin
        r_resolved_pc        <= w_head.pc;
        r_resolved_pc_target <= resolve_target;
      end
      if (w_flush) r_redirect_pc <= w_act_next;
      if (resolve_valid && w_empty) r_underflow_err <= 1'b1;
      // Statistics saturate rather than wrap.
      if (w_pop && w_is_branch && (r_branch_count != '1))
        r_branch_count <= r_branch_count + CNT_WIDTH'(1);
      if (w_flush && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
    end
  end

  assign queue_full         = w_full;
  assign update_predictor   = r_update_predictor;
  assign update_btb         = r_update_btb;
  assign actually_taken     = r_actually_taken;
  assign resolved_pc        = r_resolved_pc;
  assign resolved_pc_target = r_resolved_pc_target;
  assign redirect_valid     = r_redirect_valid;
  assign redirect_pc        = r_redirect_pc;
  assign branch_count       = r_branch_count;
  assign mispredict_count   = r_mispredict_count;
  assign underflow_err      = r_underflow_err;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: a reference model predicts every
// cycle's registered outputs, and each scenario task pops and compares them.
module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_valid, fetch_hit, fetch_pred;
  logic [31:0] fetch_pc, fetch_target;
  logic        queue_full;
  logic        resolve_valid, resolve_is_cond, resolve_is_jump, resolve_taken;
  logic [31:0] resolve_target;
  logic        update_predictor, update_btb, actually_taken;
  logic [31:0] resolved_pc, resolved_pc_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count, mispredict_count;
  logic        underflow_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolution_unit #(
    .DATA_WIDTH  (32),
    .QUEUE_DEPTH (4),
    .CNT_WIDTH   (32)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .fetch_hit          (fetch_hit),
    .fetch_pred         (fetch_pred),
    .fetch_target       (fetch_target),
    .queue_full         (queue_full),
    .resolve_valid      (resolve_valid),
    .resolve_is_cond    (resolve_is_cond),
    .resolve_is_jump    (resolve_is_jump),
    .resolve_taken      (resolve_taken),
    .resolve_target     (resolve_target),
    .update_predictor   (update_predictor),
    .update_btb         (update_btb),
    .actually_taken     (actually_taken),
    .resolved_pc        (resolved_pc),
    .resolved_pc_target (resolved_pc_target),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count),
    .underflow_err      (underflow_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  typedef struct packed {
    logic        up;
    logic        ub;
    logic        at;
    logic [31:0] rpc;
    logic [31:0] rtgt;
    logic        rv;
    logic [31:0] rdpc;
    logic [31:0] bc;
    logic [31:0] mc;
    logic        uf;
    logic        full;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  exp_t m;
  exp_t e;

  // Drives one cycle from posedge+1, records the model's expected outputs for
  // the following edge in the scoreboard, and returns at the next posedge+1.
  task automatic do_cycle(input logic fv, input logic [31:0] fpc, input logic fh,
                          input logic fp, input logic [31:0] ft, input logic rv,
                          input logic rc, input logic rj, input logic rt,
                          input logic [31:0] rtg);
    ent_t h;
    exp_t n;
    logic pop, at, flush, push;
    logic [31:0] pn, an;
    fetch_valid = fv; fetch_pc = fpc; fetch_hit = fh; fetch_pred = fp; fetch_target = ft;
    resolve_valid = rv; resolve_is_cond = rc; resolve_is_jump = rj;
    resolve_taken = rt; resolve_target = rtg;
    n = m;
    n.up = 1'b0; n.ub = 1'b0; n.at = 1'b0; n.rv = 1'b0;
    pop = rv && (mq.size() > 0);
    flush = 1'b0;
    if (rv && mq.size() == 0) n.uf = 1'b1;
    if (pop) begin
      h = mq.pop_front();
      at = rj || (rc && rt);
      pn = (h.hit && h.pred) ? h.tgt : h.pc + 32'd4;
      an = at ? rtg : h.pc + 32'd4;
      flush = (pn != an);
      n.up = rc; n.ub = at; n.at = at; n.rpc = h.pc; n.rtgt = rtg;
      if (rc || rj) n.bc = m.bc + 32'd1;
      if (flush) begin
        n.rv = 1'b1; n.rdpc = an; n.mc = m.mc + 32'd1;
        mq.delete();
      end
    end
    push = fv && (mq.size() < 4) && !flush && !m.rv;
    if (push) mq.push_back('{pc: fpc, hit: fh, pred: fp, tgt: ft});
    n.full = (mq.size() == 4);
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic hit, input logic pred,
                       input logic [31:0] tgt);
    do_cycle(1'b1, pc, hit, pred, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic cond, input logic jump, input logic tk,
                         input logic [31:0] tgt);
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, cond, jump, tk, tgt);
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if (update_predictor !== 1'b0 || update_btb !== 1'b0 || actually_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b%b%b expected 000", update_predictor, update_btb, actually_taken); end
    n_chk++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_redirect: got %b/%h expected 0/0", redirect_valid, redirect_pc); end
    n_chk++; if (branch_count !== 32'h0 || mispredict_count !== 32'h0 || underflow_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%b expected 0/0/0", branch_count, mispredict_count, underflow_err); end
    n_chk++; if (queue_full !== 1'b0 || resolved_pc !== 32'h0 || resolved_pc_target !== 32'h0) begin
      n_fail++; $display("FAIL reset_queue: got full=%b pc=%h tgt=%h expected 0", queue_full, resolved_pc, resolved_pc_target); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_correct_taken;
    fetch(32'h100, 1'b1, 1'b1, 32'h200); e = sb.pop_front();
    resolve(1'b1, 1'b0, 1'b1, 32'h200); e = sb.pop_front();
    n_chk++; if ({update_predictor, update_btb, actually_taken} !== {e.up, e.ub, e.at}) begin
      n_fail++; $display("FAIL hit_strobes: got %b%b%b expected %b%b%b", update_predictor, update_btb, actually_taken, e.up, e.ub, e.at); end
    n_chk++; if (resolved_pc !== e.rpc || resolved_pc_target !== e.rtgt) begin
      n_fail++; $display("FAIL hit_resolved: got %h/%h expected %h/%h", resolved_pc, resolved_pc_target, e.rpc, e.rtgt); end
    n_chk++; if (redirect_valid !== e.rv || branch_count !== e.bc) begin
      n_fail++; $display("FAIL hit_redir_count: got %b/%0d expected %b/%0d", redirect_valid, branch_count, e.rv, e.bc); end
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    n_chk++; if (update_predictor !== e.up || resolved_pc !== e.rpc) begin
      n_fail++; $display("FAIL hit_idle_hold: got upd=%b pc=%h expected %b/%h", update_predictor, resolved_pc, e.up, e.rpc); end
  endtask

  task automatic test_mispredict_flush;
    fetch(32'h104, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      fetch(32'h110 + 32'(4*i), 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    end
    n_chk++; if (queue_full !== e.full) begin
      n_fail++; $display("FAIL flush_prefull: got %b expected %b", queue_full, e.full); end
    resolve(1'b1, 1'b0, 1'b1, 32'h40); e = sb.pop_front();
    n_chk++; if (redirect_valid !== e.rv || redirect_pc !== e.rdpc) begin
      n_fail++; $display("FAIL flush_redirect: got %b/%h expected %b/%h", redirect_valid, redirect_pc, e.rv, e.rdpc); end
    n_chk++; if (update_btb !== e.ub || mispredict_count !== e.mc || queue_full !== e.full) begin
      n_fail++; $display("FAIL flush_state: got btb=%b mc=%0d full=%b expected %b/%0d/%b", update_btb, mispredict_count, queue_full, e.ub, e.mc, e.full); end
    fetch(32'h500, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    n_chk++; if (redirect_valid !== e.rv) begin
      n_fail++; $display("FAIL flush_one_cycle: got %b expected %b", redirect_valid, e.rv); end
    fetch(32'h600, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    resolve(1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    n_chk++; if (resolved_pc !== e.rpc || redirect_valid !== e.rv) begin
      n_fail++; $display("FAIL flush_emptied: got pc=%h redir=%b expected %h/%b", resolved_pc, redirect_valid, e.rpc, e.rv); end
  endtask

  task automatic test_btb_alias;
    fetch(32'h108, 1'b1, 1'b1, 32'h300); e = sb.pop_front();
    resolve(1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    n_chk++; if (redirect_valid !== e.rv || redirect_pc !== e.rdpc) begin
      n_fail++; $display("FAIL alias_redirect: got %b/%h expected %b/%h", redirect_valid, redirect_pc, e.rv, e.rdpc); end
    n_chk++; if (update_predictor !== e.up || update_btb !== e.ub || branch_count !== e.bc) begin
      n_fail++; $display("FAIL alias_updates: got %b%b bc=%0d expected %b%b bc=%0d", update_predictor, update_btb, branch_count, e.up, e.ub, e.bc); end
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
  endtask

  task automatic test_full_wrap;
    for (int i = 0; i < 4; i++) begin
      fetch(32'h1000 + 32'(4*i), 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    end
    n_chk++; if (queue_full !== e.full) begin
      n_fail++; $display("FAIL full_set: got %b expected %b", queue_full, e.full); end
    do_cycle(1'b1, 32'h1010, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    n_chk++; if (queue_full !== e.full || resolved_pc !== e.rpc) begin
      n_fail++; $display("FAIL full_push_pop: got full=%b pc=%h expected %b/%h", queue_full, resolved_pc, e.full, e.rpc); end
    fetch(32'h1014, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    n_chk++; if (queue_full !== e.full) begin
      n_fail++; $display("FAIL full_drop: got %b expected %b", queue_full, e.full); end
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 32'h2000 + 32'(4*i), 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      e = sb.pop_front();
      n_chk++; if (resolved_pc !== e.rpc || queue_full !== e.full || redirect_valid !== e.rv) begin
        n_fail++; $display("FAIL wrap_%0d: got pc=%h full=%b redir=%b expected %h/%b/%b", i, resolved_pc, queue_full, redirect_valid, e.rpc, e.full, e.rv); end
    end
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
      n_chk++; if (resolved_pc !== e.rpc) begin
        n_fail++; $display("FAIL drain_%0d: got %h expected %h", i, resolved_pc, e.rpc); end
    end
    n_chk++; if (queue_full !== e.full || underflow_err !== e.uf) begin
      n_fail++; $display("FAIL drain_end: got full=%b uf=%b expected %b/%b", queue_full, underflow_err, e.full, e.uf); end
  endtask

  task automatic test_jal;
    fetch(32'h700, 1'b1, 1'b0, 32'h800); e = sb.pop_front();
    resolve(1'b0, 1'b1, 1'b0, 32'h800); e = sb.pop_front();
    n_chk++; if (redirect_valid !== e.rv || redirect_pc !== e.rdpc) begin
      n_fail++; $display("FAIL jal_redirect: got %b/%h expected %b/%h", redirect_valid, redirect_pc, e.rv, e.rdpc); end
    n_chk++; if ({update_predictor, update_btb, actually_taken} !== {e.up, e.ub, e.at} || branch_count !== e.bc) begin
      n_fail++; $display("FAIL jal_updates: got %b%b%b bc=%0d expected %b%b%b bc=%0d", update_predictor, update_btb, actually_taken, branch_count, e.up, e.ub, e.at, e.bc); end
    n_chk++; if (mispredict_count !== e.mc || resolved_pc_target !== e.rtgt) begin
      n_fail++; $display("FAIL jal_stats: got mc=%0d tgt=%h expected %0d/%h", mispredict_count, resolved_pc_target, e.mc, e.rtgt); end
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
  endtask

  task automatic test_underflow_async_reset;
    resolve(1'b1, 1'b0, 1'b1, 32'h40); e = sb.pop_front();
    n_chk++; if (underflow_err !== e.uf || update_predictor !== e.up || update_btb !== e.ub) begin
      n_fail++; $display("FAIL underflow: got uf=%b upd=%b%b expected %b/%b%b", underflow_err, update_predictor, update_btb, e.uf, e.up, e.ub); end
    fetch(32'h880, 1'b1, 1'b1, 32'h900); e = sb.pop_front();
    n_chk++; if (underflow_err !== e.uf) begin
      n_fail++; $display("FAIL underflow_sticky: got %b expected %b", underflow_err, e.uf); end
    fetch(32'h884, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    resolve(1'b1, 1'b0, 1'b1, 32'h900); e = sb.pop_front();
    n_chk++; if (update_predictor !== e.up || resolved_pc !== e.rpc) begin
      n_fail++; $display("FAIL pre_reset: got upd=%b pc=%h expected %b/%h", update_predictor, resolved_pc, e.up, e.rpc); end
    #2;
    rstn = 1'b0;
    #1;
    mq.delete(); sb.delete(); m = '0;
    n_chk++; if (update_predictor !== m.up || update_btb !== m.ub || actually_taken !== m.at || resolved_pc !== m.rpc) begin
      n_fail++; $display("FAIL async_strobes: got %b%b%b pc=%h expected 000 pc=0", update_predictor, update_btb, actually_taken, resolved_pc); end
    n_chk++; if (branch_count !== m.bc || mispredict_count !== m.mc || underflow_err !== m.uf || redirect_valid !== m.rv) begin
      n_fail++; $display("FAIL async_state: got bc=%0d mc=%0d uf=%b rv=%b expected 0", branch_count, mispredict_count, underflow_err, redirect_valid); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    fetch(32'h900, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    resolve(1'b0, 1'b0, 1'b0, 32'h0); e = sb.pop_front();
    n_chk++; if (resolved_pc !== e.rpc || underflow_err !== e.uf || redirect_valid !== e.rv) begin
      n_fail++; $display("FAIL post_reset: got pc=%h uf=%b rv=%b expected %h/%b/%b", resolved_pc, underflow_err, redirect_valid, e.rpc, e.uf, e.rv); end
  endtask

  initial begin
    rstn = 1'b0;
    fetch_valid = 1'b0; fetch_pc = '0; fetch_hit = 1'b0; fetch_pred = 1'b0; fetch_target = '0;
    resolve_valid = 1'b0; resolve_is_cond = 1'b0; resolve_is_jump = 1'b0;
    resolve_taken = 1'b0; resolve_target = '0;
    m = '0;
    test_reset;
    test_correct_taken;
    test_mispredict_flush;
    test_btb_alias;
    test_full_wrap;
    test_jal;
    test_underflow_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
